// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable period timer for peripheral timebases.
// A BW-bit up-counter advances once every (prescale+1) clocks and wraps after
// reaching the latched period, emitting a one-cycle tick on each wrap.
// Periodic and one-shot modes; all outputs are registered.
//
// Ports:
//   clk_i       system clock, rising edge
//   nrst_i      asynchronous active-low reset
//   start_i     start request (honoured in IDLE and DONE only)
//   stop_i      abort to IDLE; wins over start_i
//   oneshot_i   1 = stop after first period, 0 = periodic
//   period_i    terminal count P (latched at start)
//   prescale_i  prescaler value S (latched at start), divide = S+1
//   count_o     current counter value
//   tick_o      one-cycle pulse on each period wrap
//   busy_o      high while running
//   done_o      level, one-shot completed
module timer_ctrl #(
  parameter int BW     = 8,
  parameter int PSC_BW = 4
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              oneshot_i,
  input  logic [BW-1:0]     period_i,
  input  logic [PSC_BW-1:0] prescale_i,
  output logic [BW-1:0]     count_o,
  output logic              tick_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PSC_BW-1:0]   psc;
  logic [PSC_BW-1:0]   psc_nxt;
  logic [BW-1:0]       count_nxt;
  logic                tick_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic [BW-1:0]       sh_period;
  logic [BW-1:0]       sh_period_nxt;
  logic [PSC_BW-1:0]   sh_psc;
  logic [PSC_BW-1:0]   sh_psc_nxt;
  logic                sh_oneshot;
  logic                sh_oneshot_nxt;

  logic                enable;
  logic                at_top;
  logic                launch;

  // Counter step strobe and terminal-count detect, both from shadow config only.
  always_comb begin
    enable = (psc == sh_psc);
    at_top = (count_o == sh_period);
    launch = start_i && !stop_i;
  end

  // State register together with the registered datapath and outputs.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state      <= IDLE;
      psc        <= {PSC_BW{1'b0}};
      count_o    <= {BW{1'b0}};
      tick_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      sh_period  <= {BW{1'b0}};
      sh_psc     <= {PSC_BW{1'b0}};
      sh_oneshot <= 1'b0;
    end else begin
      state      <= state_nxt;
      psc        <= psc_nxt;
      count_o    <= count_nxt;
      tick_o     <= tick_nxt;
      busy_o     <= busy_nxt;
      done_o     <= done_nxt;
      sh_period  <= sh_period_nxt;
      sh_psc     <= sh_psc_nxt;
      sh_oneshot <= sh_oneshot_nxt;
    end
  end

  // Next-state selection; stop_i has priority over everything else.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_nxt = IDLE;
        end else if (enable && at_top && sh_oneshot) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (stop_i) begin
          state_nxt = IDLE;
        end else if (start_i) begin
          state_nxt = RUN;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, prescaler and shadow config.
  always_comb begin
    psc_nxt        = {PSC_BW{1'b0}};
    count_nxt      = {BW{1'b0}};
    tick_nxt       = 1'b0;
    sh_period_nxt  = sh_period;
    sh_psc_nxt     = sh_psc;
    sh_oneshot_nxt = sh_oneshot;
    busy_nxt       = (state_nxt == RUN);
    done_nxt       = (state_nxt == DONE);
    case (state)
      IDLE, DONE: begin
        if (launch) begin
          sh_period_nxt  = period_i;
          sh_psc_nxt     = prescale_i;
          sh_oneshot_nxt = oneshot_i;
        end else begin
          sh_period_nxt  = sh_period;
        end
      end
      RUN: begin
        if (stop_i) begin
          // Abort: counter and prescaler already defaulted to zero, no tick.
          tick_nxt = 1'b0;
        end else if (enable) begin
          if (at_top) begin
            count_nxt = {BW{1'b0}};
            tick_nxt  = 1'b1;
          end else begin
            // BW-bit add; carry-out intentionally dropped.
            count_nxt = count_o + {{(BW-1){1'b0}}, 1'b1};
          end
        end else begin
          count_nxt = count_o;
          psc_nxt   = psc + {{(PSC_BW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        tick_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl. Expected outputs come from closed-form
// timing formulas (count = floor(n/(S+1)) mod (P+1), tick every (P+1)(S+1)
// cycles after start) and are queued before each clock, then popped and
// compared on the falling edge after the DUT has updated.
module tb_timer_ctrl;

  typedef struct packed {
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk;
  logic       nrst;
  logic       start;
  logic       stop;
  logic       oneshot;
  logic [7:0] period;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tick;
  logic       busy;
  logic       done;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;

  timer_ctrl #(.BW(8), .PSC_BW(4)) dut (
    .clk_i      (clk),
    .nrst_i     (nrst),
    .start_i    (start),
    .stop_i     (stop),
    .oneshot_i  (oneshot),
    .period_i   (period),
    .prescale_i (prescale),
    .count_o    (count),
    .tick_o     (tick),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs n clocks after the start edge.
  function automatic exp_t run_exp(int p, int s, bit os, int n);
    exp_t e;
    int   t;
    t = (p + 1) * (s + 1);
    if (os && n >= t) begin
      e.count = 8'd0;
      e.tick  = (n == t);
      e.busy  = 1'b0;
      e.done  = 1'b1;
    end else begin
      e.count = 8'((n / (s + 1)) % (p + 1));
      e.tick  = (n > 0) && (n % t == 0);
      e.busy  = 1'b1;
      e.done  = 1'b0;
    end
    return e;
  endfunction

  // Drive a start pulse at the next edge and queue the expectation for it.
  task automatic begin_run(int p, int s, bit os);
    period   = 8'(p);
    prescale = 4'(s);
    oneshot  = os;
    start    = 1'b1;
    sb.push_back(run_exp(p, s, os, 0));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    sb.push_back('0);
    got = sb.pop_front();
    checks++;
    if ({count, tick, busy, done} !== got) begin
      errors++;
      $display("FAIL reset_hold: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
               count, tick, busy, done, got.count, got.tick, got.busy, got.done);
    end
    nrst = 1'b1;
    repeat (2) begin
      sb.push_back('0);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL reset_idle: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
  endtask

  task automatic test_periodic();
    begin_run(3, 0, 1'b0);
    for (int n = 0; n <= 13; n++) begin
      if (n > 0) begin
        sb.push_back(run_exp(3, 0, 1'b0, n));
        @(negedge clk);
      end
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL periodic n=%0d: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 n, count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
    go_idle();
  endtask

  // Config changes and a retrigger attempt mid-run must not disturb the timing.
  task automatic test_prescaler();
    begin_run(2, 3, 1'b0);
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) begin
        if (n == 10) begin
          prescale = 4'd0;
          period   = 8'd1;
        end
        start = (n == 15);
        sb.push_back(run_exp(2, 3, 1'b0, n));
        @(negedge clk);
      end
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL prescaler n=%0d: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 n, count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
    start = 1'b0;
    go_idle();
  endtask

  task automatic test_oneshot();
    begin_run(5, 1, 1'b1);
    for (int n = 0; n <= 15; n++) begin
      if (n > 0) begin
        sb.push_back(run_exp(5, 1, 1'b1, n));
        @(negedge clk);
      end
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL oneshot n=%0d: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 n, count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
    // Restart from DONE.
    begin_run(5, 1, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) begin
        sb.push_back(run_exp(5, 1, 1'b1, n));
        @(negedge clk);
      end
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL restart n=%0d: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 n, count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
    go_idle();
  endtask

  task automatic test_stop();
    // Stop at count 2, then stop exactly on a terminal-count edge.
    for (int k = 0; k < 2; k++) begin
      begin_run((k == 0) ? 7 : 1, 0, 1'b0);
      for (int n = 0; n <= 3 - k; n++) begin
        if (n > 0 && n < 3 - k) begin
          sb.push_back(run_exp((k == 0) ? 7 : 1, 0, 1'b0, n));
          @(negedge clk);
        end else if (n == 3 - k) begin
          stop = 1'b1;
          start = 1'b1;
          sb.push_back('0);
          @(negedge clk);
          stop = 1'b0;
          start = 1'b0;
        end
        got = sb.pop_front();
        checks++;
        if ({count, tick, busy, done} !== got) begin
          errors++;
          $display("FAIL stop k=%0d n=%0d: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                   k, n, count, tick, busy, done, got.count, got.tick, got.busy, got.done);
        end
      end
    end
    // start and stop together in IDLE: stays idle.
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) begin
      sb.push_back('0);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL start_stop_idle: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_boundaries();
    int ps[3] = '{0, 0, 255};
    int ss[3] = '{0, 2, 0};
    int ns[3] = '{8, 10, 259};
    for (int k = 0; k < 3; k++) begin
      begin_run(ps[k], ss[k], 1'b0);
      for (int n = 0; n <= ns[k]; n++) begin
        if (n > 0) begin
          sb.push_back(run_exp(ps[k], ss[k], 1'b0, n));
          @(negedge clk);
        end
        got = sb.pop_front();
        checks++;
        if ({count, tick, busy, done} !== got) begin
          errors++;
          $display("FAIL boundary P=%0d S=%0d n=%0d: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                   ps[k], ss[k], n, count, tick, busy, done, got.count, got.tick, got.busy, got.done);
        end
      end
      go_idle();
    end
  endtask

  task automatic test_async_reset();
    begin_run(9, 0, 1'b0);
    for (int n = 0; n <= 3; n++) begin
      if (n > 0) begin
        sb.push_back(run_exp(9, 0, 1'b0, n));
        @(negedge clk);
      end
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL pre_reset n=%0d: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 n, count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
    // Reset lands between clock edges and must act without one.
    #2 nrst = 1'b0;
    sb.push_back('0);
    #1;
    got = sb.pop_front();
    checks++;
    if ({count, tick, busy, done} !== got) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
               count, tick, busy, done, got.count, got.tick, got.busy, got.done);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (5) begin
      sb.push_back('0);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if ({count, tick, busy, done} !== got) begin
        errors++;
        $display("FAIL post_reset_idle: got cnt=%0d tick=%b busy=%b done=%b, exp cnt=%0d tick=%b busy=%b done=%b",
                 count, tick, busy, done, got.count, got.tick, got.busy, got.done);
      end
    end
  endtask

  initial begin
    nrst     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    oneshot  = 1'b0;
    period   = 8'd0;
    prescale = 4'd0;
    test_reset();
    test_periodic();
    test_prescaler();
    test_oneshot();
    test_stop();
    test_boundaries();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
